// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared definitions for the two-master RAM arbiter.
//   - arbiter state encoding
//   - master index constants (bit positions in the one-hot grant)
//   - byte-select size encodings understood by the RAM slave
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

    localparam int WB_M_DATA = 0;
    localparam int WB_M_INSN = 1;

    // sel carries an access size, not a lane mask; the RAM picks the lane
    // from the low address bits.
    localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
    localparam logic [3:0] WB_SEL_HALF = 4'b0011;
    localparam logic [3:0] WB_SEL_WORD = 4'b1111;

endpackage

// File: rtl/wb_ram_arbiter_rr.sv
// rr_arbiter_2: combinational two-way round-robin pick.
//   req[1:0]      - requests from master 0 / master 1
//   last          - index of the master granted most recently
//   gnt_next[1:0] - one-hot winner (zero when nobody requests)
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt_next
);

    always_comb begin
        gnt_next = req;
        // On a tie the master that did not win last time goes first.
        if (req == 2'b11) begin
            gnt_next = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: shares one single-port Wishbone RAM between the core data
// port (master 0) and instruction fetch (master 1).
//   wb_clk_i / wb_rst_i        - clock, asynchronous active-low reset
//   mN_*_i                     - master request signals (N = 0, 1)
//   mN_data_o/ack_o/err_o      - master responses
//   s_*_o / s_data_i / s_ack_i - slave port
//   grant_o                    - one-hot current grant (debug)
// A granted transaction is held until ack, abort or timeout, then one HOLD
// cycle gives the RAM its idle cycle before the next grant.
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = WB_DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16   // must be >= 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,

    input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
    input  logic                     m0_we_i,
    input  logic                     m0_cyc_i,
    input  logic                     m0_stb_i,
    output logic [WB_DATA_WIDTH-1:0] m0_data_o,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,

    input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
    input  logic                     m1_we_i,
    input  logic                     m1_cyc_i,
    input  logic                     m1_stb_i,
    output logic [WB_DATA_WIDTH-1:0] m1_data_o,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,

    output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
    output logic [WB_DATA_WIDTH-1:0] s_data_o,
    output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
    output logic                     s_we_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    input  logic [WB_DATA_WIDTH-1:0] s_data_i,
    input  logic                     s_ack_i,

    output logic [1:0]               grant_o
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       r_state;
    logic [1:0]       r_grant;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0] w_req;
    logic [1:0] w_gnt_next;
    logic       w_busy;
    logic       w_gcyc;
    logic       w_greq;
    logic       w_ack;
    logic       w_tmo;

    assign w_req[WB_M_DATA] = m0_cyc_i & m0_stb_i;
    assign w_req[WB_M_INSN] = m1_cyc_i & m1_stb_i;

    rr_arbiter_2 u_rr (
        .req      (w_req),
        .last     (r_last),
        .gnt_next (w_gnt_next)
    );

    assign w_busy = (r_state == ST_BUSY);
    assign w_gcyc = (r_grant[WB_M_DATA] & m0_cyc_i) | (r_grant[WB_M_INSN] & m1_cyc_i);
    assign w_greq = |(r_grant & w_req);

    // Slave ack reaches the master combinationally; ack beats timeout, and a
    // master that already dropped cyc gets neither.
    assign w_ack = w_busy & s_ack_i & w_greq;
    assign w_tmo = w_busy & w_gcyc & ~w_ack & (r_cnt == CNT_MAX);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_gnt_next;
                        r_last  <= w_gnt_next[WB_M_INSN];
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_ack || !w_gcyc || w_tmo) begin
                        r_grant <= 2'b00;
                        r_state <= ST_HOLD;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: r_state <= ST_IDLE;
                default: begin
                    r_grant <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o  = r_grant;
    assign s_cyc_o  = w_busy;
    assign s_stb_o  = w_busy;

    assign m0_ack_o = w_ack & r_grant[WB_M_DATA];
    assign m1_ack_o = w_ack & r_grant[WB_M_INSN];
    assign m0_err_o = w_tmo & r_grant[WB_M_DATA];
    assign m1_err_o = w_tmo & r_grant[WB_M_INSN];

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        if (w_busy && r_grant[WB_M_INSN]) begin
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
        end else if (w_busy && r_grant[WB_M_DATA]) begin
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: behavioural RAM slave, per-cycle reference model
// of the arbitration rules, and directed scenarios with literal expectations.
module tb_wb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    logic          wb_clk_i, wb_rst_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i, s_addr_o;
    logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o, s_data_o, s_data_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]    grant_o;

    wb_ram_arbiter #(
        .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .WB_SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural RAM slave ----------------
    // Reads and full-word writes ack one cycle after the strobe is seen,
    // sub-word writes (read-modify-write) two cycles after.
    logic [31:0] mem [0:15];
    logic [31:0] sl_data;
    logic        sl_ack;
    int          sl_cnt;
    logic        sl_noack;   // slave never answers
    logic        f_ack;      // stray ack injected by the stimulus
    int          sl_lat;
    int          sl_lane;

    assign s_ack_i  = sl_ack | f_ack;
    assign s_data_i = sl_data;

    always @(posedge wb_clk_i) begin
        sl_ack <= 1'b0;
        if (s_cyc_o && s_stb_o && !sl_ack && !sl_noack) begin
            sl_lat = (s_we_o && s_sel_o != SEL_WORD) ? 2 : 1;
            if (sl_cnt + 1 >= sl_lat) begin
                sl_ack <= 1'b1;
                sl_cnt <= 0;
                if (s_we_o) begin
                    if (s_sel_o == SEL_BYTE) begin
                        sl_lane = int'(s_addr_o[1:0]);
                        mem[s_addr_o[5:2]][8*sl_lane +: 8] <= s_data_o[7:0];
                    end else if (s_sel_o == SEL_HALF) begin
                        sl_lane = int'(s_addr_o[1]);
                        mem[s_addr_o[5:2]][16*sl_lane +: 16] <= s_data_o[15:0];
                    end else begin
                        mem[s_addr_o[5:2]] <= s_data_o;
                    end
                end else begin
                    sl_data <= mem[s_addr_o[5:2]];
                end
            end else begin
                sl_cnt <= sl_cnt + 1;
            end
        end else begin
            sl_cnt <= 0;
        end
    end

    // ---------------- reference model ----------------
    // m_st: 0 no grant, 1 transaction in progress, 2 idle gap after it.
    int         m_st   = 0;
    int         m_own  = 0;
    int         m_last = 1;
    int         m_cnt  = 0;
    logic [1:0] m_req;
    logic       m_busy, m_gcyc, m_ack, m_err;

    always @(negedge wb_rst_i) begin
        m_st = 0; m_last = 1; m_cnt = 0;
    end

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            m_st = 0; m_last = 1; m_cnt = 0;
        end
        m_req  = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
        m_busy = wb_rst_i && (m_st == 1);
        m_gcyc = (m_own == 1) ? m1_cyc_i : m0_cyc_i;
        m_ack  = m_busy && s_ack_i && m_req[m_own];
        m_err  = m_busy && !m_ack && m_gcyc && (m_cnt == TO - 1);

        cmp("grant", grant_o, !m_busy ? 2'b00 : (m_own == 1 ? 2'b10 : 2'b01));
        cmp("s_cyc", s_cyc_o, m_busy);
        cmp("s_stb", s_stb_o, m_busy);
        cmp("s_addr", s_addr_o, !m_busy ? 32'h0 : (m_own == 1 ? m1_addr_i : m0_addr_i));
        cmp("s_wdata", s_data_o, !m_busy ? 32'h0 : (m_own == 1 ? m1_data_i : m0_data_i));
        cmp("s_sel", s_sel_o, !m_busy ? 4'h0 : (m_own == 1 ? m1_sel_i : m0_sel_i));
        cmp("s_we", s_we_o, m_busy && (m_own == 1 ? m1_we_i : m0_we_i));
        cmp("m0_ack", m0_ack_o, m_ack && m_own == 0);
        cmp("m1_ack", m1_ack_o, m_ack && m_own == 1);
        cmp("m0_err", m0_err_o, m_err && m_own == 0);
        cmp("m1_err", m1_err_o, m_err && m_own == 1);
        cmp("m0_rdata", m0_data_o, s_data_i);
        cmp("m1_rdata", m1_data_o, s_data_i);

        if (wb_rst_i) begin
            case (m_st)
                0: if (m_req != 2'b00) begin
                    if (m_req == 2'b11) m_own = (m_last == 1) ? 0 : 1;
                    else                m_own = m_req[1] ? 1 : 0;
                    m_last = m_own;
                    m_cnt  = 0;
                    m_st   = 1;
                end
                1: begin
                    if (m_ack || !m_gcyc || m_err) m_st = 2;
                    else if (m_cnt < TO - 1)       m_cnt++;
                end
                default: m_st = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge wb_clk_i);
    endtask

    task automatic m0_set(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, input logic r);
        m0_addr_i = a; m0_data_i = d; m0_sel_i = s; m0_we_i = w; m0_cyc_i = r; m0_stb_i = r;
    endtask

    task automatic m1_set(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, input logic r);
        m1_addr_i = a; m1_data_i = d; m1_sel_i = s; m1_we_i = w; m1_cyc_i = r; m1_stb_i = r;
    endtask

    int errcnt;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        mem[0] <= 32'h11223344;
        mem[4] <= 32'hDEADBEEF;
        mem[8] <= 32'hCAFEF00D;
        sl_data = 32'h0; sl_ack = 1'b0; sl_cnt = 0;
        sl_noack = 1'b0; f_ack = 1'b0;
        wb_rst_i = 1'b0;
        m0_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        m1_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

        repeat (2) step();
        smp();
        cmp("lit_rst_grant", grant_o, 2'b00);
        cmp("lit_rst_stb", s_stb_o, 1'b0);
        cmp("lit_rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
        step(); wb_rst_i = 1'b1;
        step();

        // single master word read at 0x10
        step(); m0_set(32'h10, 32'h0, SEL_WORD, 1'b0, 1'b1);
        smp();  cmp("lit_single_T_stb", s_stb_o, 1'b0);
        step(); smp();
        cmp("lit_single_T1_stb", s_stb_o, 1'b1);
        cmp("lit_single_T1_grant", grant_o, 2'b01);
        cmp("lit_single_T1_addr", s_addr_o, 32'h10);
        step(); smp();
        cmp("lit_single_T2_ack", m0_ack_o, 1'b1);
        cmp("lit_single_T2_data", m0_data_o, 32'hDEADBEEF);
        step(); m0_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        smp();  cmp("lit_single_T3_stb", s_stb_o, 1'b0);
        step(); step();

        // reset in the middle of a granted read; a late ack must not leak
        step(); m0_set(32'h14, 32'h0, SEL_WORD, 1'b0, 1'b1); sl_noack = 1'b1;
        step(); smp();
        cmp("lit_rstmid_grant_before", grant_o, 2'b01);
        #1 wb_rst_i = 1'b0;
        #1;
        cmp("lit_rstmid_grant", grant_o, 2'b00);
        cmp("lit_rstmid_stb", s_stb_o, 1'b0);
        cmp("lit_rstmid_ack", {m0_ack_o, m1_ack_o}, 2'b00);
        m0_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        step(); wb_rst_i = 1'b1; sl_noack = 1'b0; f_ack = 1'b1;
        smp();  cmp("lit_rstmid_late_ack", m0_ack_o, 1'b0);
        step(); f_ack = 1'b0;
        step();

        // contention from reset: grants alternate 01,10,01,10 with a gap
        step();
        m0_set(32'h10, 32'h0, SEL_WORD, 1'b0, 1'b1);
        m1_set(32'h20, 32'h0, SEL_WORD, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) begin
            smp();
            case (k)
                1:  cmp("lit_cont_g1", grant_o, 2'b01);
                2:  cmp("lit_cont_m1_noack", m1_ack_o, 1'b0);
                3:  cmp("lit_cont_hold", grant_o, 2'b00);
                5:  cmp("lit_cont_g2", grant_o, 2'b10);
                6:  cmp("lit_cont_m1_data", {31'h0, m1_ack_o} + m1_data_o, 32'hCAFEF00E);
                9:  cmp("lit_cont_g3", grant_o, 2'b01);
                13: cmp("lit_cont_g4", grant_o, 2'b10);
                default: ;
            endcase
            step();
        end
        m0_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        m1_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        step(); step();

        // M1 byte write 0xAB at address 0x3
        step(); m1_set(32'h3, 32'hAB, SEL_BYTE, 1'b1, 1'b1);
        smp();
        step(); smp(); cmp("lit_sub_T1_grant", grant_o, 2'b10);
        step(); smp(); cmp("lit_sub_T2_noack", m1_ack_o, 1'b0);
        step(); smp(); cmp("lit_sub_T3_ack", m1_ack_o, 1'b1);
        step(); m1_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        smp();  cmp("lit_sub_T4_stb", s_stb_o, 1'b0);
        cmp("lit_sub_mem", mem[0], 32'hAB223344);
        step(); step();

        // timeout on M0, M1 waiting behind it
        step(); m0_set(32'h10, 32'h0, SEL_WORD, 1'b0, 1'b1); sl_noack = 1'b1;
        errcnt = 0;
        for (int k = 0; k < 21; k++) begin
            smp();
            if (m0_err_o) errcnt++;
            case (k)
                15: cmp("lit_tmo_T15_err", m0_err_o, 1'b0);
                16: cmp("lit_tmo_T16_err", m0_err_o, 1'b1);
                17: cmp("lit_tmo_T17_hold", grant_o, 2'b00);
                19: cmp("lit_tmo_m1_grant", grant_o, 2'b10);
                20: cmp("lit_tmo_m1_ack", m1_ack_o, 1'b1);
                default: ;
            endcase
            step();
            if (k + 1 == 2) m1_set(32'h20, 32'h0, SEL_WORD, 1'b0, 1'b1);
            if (k + 1 == 17) begin
                m0_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
                sl_noack = 1'b0;
            end
        end
        m1_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        cmp("lit_tmo_err_cycles", errcnt, 1);
        step(); step();

        // M1 aborts in its first BUSY cycle, pending M0 is served next
        step(); m1_set(32'h20, 32'h0, SEL_WORD, 1'b0, 1'b1);
        smp();
        step(); m1_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        m0_set(32'h10, 32'h0, SEL_WORD, 1'b0, 1'b1);
        smp();
        cmp("lit_abort_T1_grant", grant_o, 2'b10);
        cmp("lit_abort_T1_resp", {m1_ack_o, m1_err_o}, 2'b00);
        step(); smp();
        cmp("lit_abort_T2_hold", grant_o, 2'b00);
        cmp("lit_abort_T2_resp", {m1_ack_o, m1_err_o}, 2'b00);
        step(); smp(); cmp("lit_abort_T3_idle", grant_o, 2'b00);
        step(); smp(); cmp("lit_abort_T4_grant", grant_o, 2'b01);
        step(); smp();
        cmp("lit_abort_T5_ack", m0_ack_o, 1'b1);
        cmp("lit_abort_T5_data", m0_data_o, 32'hDEADBEEF);
        step(); m0_set(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_ram_arbiter.md
# wb_ram_arbiter

- Two-master Wishbone arbiter that shares the single-port `wb_ram_new` slave.
- Master 0 is the core data port; master 1 is instruction fetch.
- Grants the slave to one master at a time with round-robin priority and holds it until that transaction ends.
- Inserts the one idle cycle the RAM needs after every ack, and answers a stalled slave with a bus error after a bounded number of cycles.

## Interface
- `WB_DATA_WIDTH`, 32: data width of both masters and the slave.
- `WB_ADDR_WIDTH`, 32: address width.
- `WB_SEL_WIDTH`, `WB_DATA_WIDTH/8`: byte-select width.
- `TIMEOUT_CYCLES`, 16: BUSY cycles without a slave ack before an error is returned; must be ≥ 4.

Ports:
- `wb_clk_i` in 1: single clock; every register is on its rising edge.
- `wb_rst_i` in 1: asynchronous, active-low reset.
- `mN_addr_i` in `WB_ADDR_WIDTH` (N = 0, 1): master address.
- `mN_data_i` in `WB_DATA_WIDTH`: master write data.
- `mN_sel_i` in `WB_SEL_WIDTH`: master byte select.
- `mN_we_i`, `mN_cyc_i`, `mN_stb_i` in 1: master write enable, cycle, strobe.
- `mN_data_o` out `WB_DATA_WIDTH`: read data, equal to `s_data_i` for both masters.
- `mN_ack_o` out 1: transaction acknowledge to master N.
- `mN_err_o` out 1: timeout error to master N.
- `s_addr_o`, `s_data_o`, `s_sel_o`, `s_we_o` out: the granted master's signals; all zero when nothing is granted.
- `s_cyc_o`, `s_stb_o` out 1: slave cycle and strobe.
- `s_data_i` in `WB_DATA_WIDTH`: slave read data.
- `s_ack_i` in 1: slave acknowledge.
- `grant_o` out 2: one-hot current grant, for debug and verification.

## Operation
- `req[N] = mN_cyc_i & mN_stb_i`.
- State machine with three states:
  - IDLE: no grant.
    - Any request: register the grant, load it into `last`, clear the timeout counter, go to BUSY.
    - Both masters request: the master not equal to `last` wins.
    - One master requests: that master wins.
  - BUSY: the slave port drives the granted master's signals with `s_cyc_o = s_stb_o = 1`.
    - `s_ack_i` and the granted master's `req` both high: pass `mN_ack_o = 1` for that cycle, go to HOLD.
    - Granted master drops `cyc` (abort): go to HOLD, with no ack or error to the master.
    - Counter reaches `TIMEOUT_CYCLES - 1` with no ack: `mN_err_o = 1` for that cycle, go to HOLD.
    - If ack and timeout coincide, the ack wins.
  - HOLD: `s_cyc_o = s_stb_o = 0` and `grant_o = 0`; always go to IDLE on the next cycle.
- `last` resets to master 1, so master 0 wins the first tie.
- The non-granted master never sees `ack` or `err`.
- The `s_ack_i` path to `mN_ack_o` is combinational, gated only by the grant and state.
- A slave ack outside BUSY is ignored.
- Read data passes through unmodified; byte and half-word lane selection stays in the slave.
- Multi-cycle slave accesses (sub-word read-modify-write writes, ack two cycles after strobe) are covered by the timeout budget.

## Timing
- Reset (asynchronous, any state, including mid-transaction): state IDLE, `grant_o = 0`, `last = 1`, counter 0.
  - All `mN_ack_o`, `mN_err_o`, `s_cyc_o`, `s_stb_o` are 0.
  - A slave already mid-access completes on its own; its late ack is ignored.
- Full-word transaction:
  - Request seen in cycle T; grant and `s_stb_o` in T+1.
  - Slave ack and master ack in T+2; HOLD in T+3.
  - Next grant can be registered at the end of T+4, so `s_stb_o` for the next transaction is in T+5.
- Sub-word write: master ack in T+3; the slave's own idle cycle overlaps HOLD.
- Timeout:
  - The counter increments each BUSY cycle and saturates.
  - `err` is asserted in the `TIMEOUT_CYCLES`-th BUSY cycle.
- Masters must hold `cyc`, `stb` and all address/data/sel/we signals stable until ack or err.
- A master must deassert `stb` in the cycle after ack or err; if `req` is still high, the arbiter treats it as a new request in IDLE.

## Structure
- Package `wb_arb_pkg`:
  - State encoding: IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2.
  - Master index constants: `WB_M_DATA = 0`, `WB_M_INSN = 1`.
  - `WB_SEL_BYTE`, `WB_SEL_HALF`, `WB_SEL_WORD` encodings, shared with the RAM.
- Sub-module `rr_arbiter_2`: combinational two-way round-robin; inputs `req[1:0]` and `last`, output one-hot `gnt_next[1:0]`.
- Top level: state register, grant register, timeout counter, and output multiplexing.

## Test plan
- Reset mid-BUSY: M0 word read granted, `wb_rst_i` pulsed low for 1 cycle → `s_stb_o`, `grant_o` and all acks go to 0 immediately; the slave's following ack does not reach M0.
- Single master: M0 word read at 0x10, slave returns 0xDEADBEEF → `s_stb_o` at T+1, `m0_ack_o` with `m0_data_o = 0xDEADBEEF` at T+2, `s_stb_o = 0` at T+3.
- Contention: M0 and M1 request together from reset, then keep requesting → grant order 01, 10, 01, 10, with one HOLD cycle between grants; M1 never sees an ack during M0's grant.
- Sub-word write: M1 writes byte 0xAB, sel 4'b0001, address 0x3, against a behavioural RAM model → ack at T+3; the RAM word reads 0xAB in bits 31:24 with the other bytes unchanged.
- Timeout: slave model never acks for an M0 request → `m0_err_o` is high for exactly one cycle in the 16th BUSY cycle; M1 is granted after HOLD.
- Abort: M1 drops `cyc` in its first BUSY cycle → no ack or err to M1; state goes BUSY, HOLD, IDLE; a pending M0 request is served next.
